imem_loader: RTL and testbench

Byte-stream boot loader that fills the core's instruction memory. It accepts a framed program image one byte at a time over a valid/ready stream (typically fed by the UART receiver), packs the bytes into little-endian 32-bit words, and writes them to consecutive word addresses of the instruction memory's write port. It holds the core in reset until a complete image with a correct checksum has been written.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/imem_loader_if.sv | 26 ++
 rtl/ldr_word_pack.sv | 50 +++++
 rtl/imem_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Contents: loader FSM state enum, frame magic byte, word-count width and
// a checksum helper.
package loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StCsum,
        StDone,
        StErr
    } ldr_state_t;

    localparam logic [7:0]  LDR_MAGIC = 8'hA5;
    localparam int unsigned LDR_CNT_W = 16;

    typedef logic [LDR_CNT_W-1:0] ldr_cnt_t;

    // 8-bit modular running sum of payload bytes.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Bus bundle between the boot loader and its environment.
// Byte stream in : s_valid, s_data (to loader), s_ready (from loader).
// Memory write   : wr_en, wr_addr, wr_data (from loader), wr_ready (to loader).
// Modports: master = loader side (drives s_ready and the write port),
//           slave  = environment side (byte source and instruction memory).
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        input  s_valid, s_data, wr_ready,
        output s_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output s_valid, s_data, wr_ready,
        input  s_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/ldr_word_pack.sv
// Packs payload bytes into a little-endian 32-bit word.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : restart packing at byte 0 (new frame)
//   byte_en     : accept byte_in this cycle
//   byte_in     : payload byte
//   word        : word including the byte being accepted this cycle
//   word_valid  : strobe, byte_en on the 4th byte of a word; word is complete
module ldr_word_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  idx_q;
    logic [31:0] word_q;

    // Insert the incoming byte at its lane so the full word is visible on the
    // same cycle as the 4th byte's handshake.
    always_comb begin
        word = word_q;
        unique case (idx_q)
            2'd0: word[7:0]   = byte_in;
            2'd1: word[15:8]  = byte_in;
            2'd2: word[23:16] = byte_in;
            2'd3: word[31:24] = byte_in;
            default: word = word_q;
        endcase
    end

    assign word_valid = byte_en && (idx_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (clear) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (byte_en) begin
            idx_q  <= idx_q + 2'd1;
            word_q <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream boot loader for the instruction memory.
// Frame: A5, N[7:0], N[15:8], N*4 payload bytes (LE words), 8-bit payload sum.
// Words go to consecutive word addresses from 0; the core is held in reset
// until a full image with a good checksum has been written.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : imem_loader_if.master (byte stream in, memory write port out)
//   core_hold  : holds the core in reset
//   done       : image loaded, checksum good (level)
//   err        : load failed (level)
// Parameters: ADDR_W (byte-address width), TIMEOUT_CYC (inter-byte timeout).
// Optional feature: define LOADER_TIMEOUT_EN to enable the inter-byte timeout.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic           clk,
    input  logic           rst,
    imem_loader_if.master  bus,
    output logic           core_hold,
    output logic           done,
    output logic           err
);

    localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);

    ldr_state_t        state_q, state_d;
    logic              rdy_q;
    logic [7:0]        len_lo_q;
    ldr_cnt_t          cnt_q;
    ldr_cnt_t          words_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        csum_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              hold_q;
    logic              done_q;
    logic              err_q;

    logic              wr_stall;
    logic              byte_xfer;
    logic              all_in;
    logic              pack_en;
    logic [31:0]       pack_word;
    logic              word_valid;
    ldr_cnt_t          len_full;
    logic              start;
    logic              load_ok;
    logic              load_bad;

    assign wr_stall  = wr_en_q && !bus.wr_ready;
    assign byte_xfer = bus.s_valid && bus.s_ready;
    assign all_in    = (words_q == cnt_q);
    assign pack_en   = byte_xfer && (state_q == StData) && !all_in;
    assign len_full  = {bus.s_data, len_lo_q};

    ldr_word_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .byte_en    (pack_en),
        .byte_in    (bus.s_data),
        .word       (pack_word),
        .word_valid (word_valid)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             tmo_active;
    logic             tmo_fire;

    assign tmo_active = (state_q == StLen0) || (state_q == StLen1) ||
                        (state_q == StData) || (state_q == StCsum);
    assign tmo_fire   = tmo_active && !byte_xfer && !wr_stall &&
                        (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Idle-cycle counter; frozen while the memory is back-pressuring us.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (!tmo_active || byte_xfer) begin
            tmo_q <= '0;
        end else if (!wr_stall) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        load_ok  = 1'b0;
        load_bad = 1'b0;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (byte_xfer && (bus.s_data == LDR_MAGIC)) begin
                    state_d = StLen0;
                    start   = 1'b1;
                end
            end
            StLen0: begin
                if (byte_xfer) state_d = StLen1;
            end
            StLen1: begin
                if (byte_xfer) begin
                    if (32'(len_full) > DEPTH) begin
                        state_d  = StErr;
                        load_bad = 1'b1;
                    end else if (len_full == '0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                // All words received: wait here until the last write is
                // accepted. A byte that arrives meanwhile can only transfer in
                // the accepting cycle, and it is the checksum.
                if (all_in) begin
                    if (byte_xfer) begin
                        if (bus.s_data == csum_q) begin
                            state_d = StDone;
                            load_ok = 1'b1;
                        end else begin
                            state_d  = StErr;
                            load_bad = 1'b1;
                        end
                    end else if (!wr_stall) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (byte_xfer) begin
                    if (bus.s_data == csum_q) begin
                        state_d = StDone;
                        load_ok = 1'b1;
                    end else begin
                        state_d  = StErr;
                        load_bad = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef LOADER_TIMEOUT_EN
        if (tmo_fire) begin
            state_d  = StErr;
            load_bad = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q     <= 1'b0;
            len_lo_q  <= 8'd0;
            cnt_q     <= '0;
            words_q   <= '0;
            addr_q    <= '0;
            csum_q    <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 32'd0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (start) begin
                words_q <= '0;
                addr_q  <= '0;
                csum_q  <= 8'd0;
                hold_q  <= 1'b1;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
            end
            if (byte_xfer && (state_q == StLen0)) len_lo_q <= bus.s_data;
            if (byte_xfer && (state_q == StLen1)) cnt_q <= len_full;
            if (pack_en) csum_q <= csum_add(csum_q, bus.s_data);
            // A new word cannot complete while a write is pending: bytes are
            // blocked during a stall and a write never outlives one byte slot.
            if (word_valid) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= pack_word;
                addr_q    <= addr_q + ADDR_W'(4);
                words_q   <= words_q + ldr_cnt_t'(1);
            end else if (wr_en_q && bus.wr_ready) begin
                wr_en_q <= 1'b0;
            end
            if (load_ok) begin
                done_q <= 1'b1;
                hold_q <= 1'b0;
            end
            if (load_bad) begin
                err_q  <= 1'b1;
                hold_q <= 1'b1;
            end
        end
    end

    assign bus.s_ready = rdy_q && !wr_stall;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign core_hold   = hold_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames, a frame-level model
// predicting writes and status, and a per-cycle compare process.
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << (ADDR_W - 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic core_hold, done, err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .core_hold (core_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic              exp_done = 1'b0;
    logic              exp_err  = 1'b0;
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    logic [ADDR_W-1:0] cap_addr[$];
    logic [31:0]       cap_data[$];
    logic [7:0]        stream[$];
    bit                active      = 1'b0;
    int                stall_left  = 0;
    int                stall_seen  = 0;
    int                ready_waits = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Memory side: accept writes, optionally stalling the next one.
    initial begin
        bus.wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && bus.wr_en) begin
                bus.wr_ready = 1'b0;
                stall_left--;
            end else begin
                bus.wr_ready = 1'b1;
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        logic              prev_stall;
        logic [ADDR_W-1:0] prev_addr;
        logic [31:0]       prev_data;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!active) begin
                prev_stall = 1'b0;
                continue;
            end
            check("done", done, exp_done);
            check("err", err, exp_err);
            check("core_hold", core_hold, !exp_done);
            check("s_ready", bus.s_ready, !(bus.wr_en && !bus.wr_ready));
            if (prev_stall) begin
                check("wr_en_held", bus.wr_en, 1'b1);
                check("wr_addr_stable", bus.wr_addr, prev_addr);
                check("wr_data_stable", bus.wr_data, prev_data);
            end
            if (bus.wr_en && !bus.wr_ready) stall_seen++;
            if (bus.wr_en && bus.wr_ready) begin
                cap_addr.push_back(bus.wr_addr);
                cap_data.push_back(bus.wr_data);
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    check("wr_addr", bus.wr_addr, exp_addr_q.pop_front());
                    check("wr_data", bus.wr_data, exp_data_q.pop_front());
                end
            end
            prev_stall = bus.wr_en && !bus.wr_ready;
            prev_addr  = bus.wr_addr;
            prev_data  = bus.wr_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int waits = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        @(negedge clk);
        while (!bus.s_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        ready_waits += waits;
        if (!bus.s_ready) check("byte_accept_bound", 0, 1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    // Frame-level model: locate the magic byte, read N, derive the expected
    // writes and the byte after which done/err must change, then send.
    task automatic run_stream();
        int         n   = stream.size();
        int         p   = -1;
        int         dec = -1;
        int         nw;
        logic       dec_d = 1'b0;
        logic       dec_e = 1'b0;
        logic [7:0] sum;
        for (int i = 0; i < n; i++) if (p < 0 && stream[i] == 8'hA5) p = i;
        if (p >= 0 && p + 2 < n) begin
            nw = int'(stream[p+1]) + 256 * int'(stream[p+2]);
            if (nw > DEPTH) begin
                dec   = p + 2;
                dec_e = 1'b1;
            end else begin
                sum = 8'd0;
                for (int w = 0; w < nw; w++) begin
                    if (p + 6 + 4 * w < n) begin
                        exp_addr_q.push_back(ADDR_W'(4 * w));
                        exp_data_q.push_back({stream[p+6+4*w], stream[p+5+4*w],
                                              stream[p+4+4*w], stream[p+3+4*w]});
                    end
                    for (int k = 0; k < 4; k++) if (p + 3 + 4 * w + k < n) sum += stream[p+3+4*w+k];
                end
                if (p + 3 + 4 * nw < n) begin
                    dec   = p + 3 + 4 * nw;
                    dec_d = (stream[dec] == sum);
                    dec_e = !dec_d;
                end
            end
        end
        ready_waits = 0;
        for (int i = 0; i < n; i++) begin
            send_byte(stream[i]);
            if (i == p) begin
                exp_done = 1'b0;
                exp_err  = 1'b0;
            end
            if (i == dec) begin
                exp_done = dec_d;
                exp_err  = dec_e;
            end
        end
        stream.delete();
        repeat (3) @(posedge clk);
        #1;
        check("writes_outstanding", exp_addr_q.size(), 0);
    endtask

    task automatic normal_frame(input logic [7:0] csum);
        cap_addr.delete();
        cap_data.delete();
        stream = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h00, 8'h00, csum};
        run_stream();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_core_hold", core_hold, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("s_ready_after_reset", bus.s_ready, 1);
        active = 1'b1;

        // Normal load, one byte per cycle, no stalls.
        normal_frame(8'hA6);
        check("normal_count", cap_addr.size(), 2);
        check("normal_addr0", cap_addr[0], 10'h000);
        check("normal_data0", cap_data[0], 32'h0000_0013);
        check("normal_addr1", cap_addr[1], 10'h004);
        check("normal_data1", cap_data[1], 32'h0000_0093);
        check("normal_no_stall", ready_waits, 0);
        check("normal_done", done, 1);
        check("normal_hold", core_hold, 0);
        check("normal_err", err, 0);

        // Bad checksum.
        normal_frame(8'hA7);
        check("badsum_count", cap_addr.size(), 2);
        check("badsum_err", err, 1);
        check("badsum_done", done, 0);
        check("badsum_hold", core_hold, 1);

        // Empty image behind a garbage prefix.
        cap_addr.delete();
        stream = {8'hFF, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};
        run_stream();
        check("empty_count", cap_addr.size(), 0);
        check("empty_done", done, 1);
        check("empty_err", err, 0);

        // Oversize count (257 > 256 words), trailing bytes ignored.
        cap_addr.delete();
        stream = {8'hA5, 8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88};
        run_stream();
        check("oversize_count", cap_addr.size(), 0);
        check("oversize_err", err, 1);
        check("oversize_hold", core_hold, 1);

        // Back-pressure on the first write for 3 cycles.
        stall_seen = 0;
        stall_left = 3;
        normal_frame(8'hA6);
        check("bp_stall_cycles", stall_seen, 3);
        check("bp_ready_waits", ready_waits, 3);
        check("bp_count", cap_addr.size(), 2);
        check("bp_data0", cap_data[0], 32'h0000_0013);
        check("bp_done", done, 1);

        // Full-depth image: 256 words, bytes 0..255 repeating.
        cap_addr.delete();
        cap_data.delete();
        begin
            logic [7:0] s;
            s = 8'd0;
            stream = {8'hA5, 8'h00, 8'h01};
            for (int i = 0; i < 4 * DEPTH; i++) begin
                stream.push_back(8'(i));
                s += 8'(i);
            end
            stream.push_back(s);
        end
        run_stream();
        check("full_count", cap_addr.size(), 256);
        check("full_first_data", cap_data[0], 32'h0302_0100);
        check("full_last_addr", cap_addr[255], 10'h3FC);
        check("full_last_data", cap_data[255], 32'hFFFE_FDFC);
        check("full_done", done, 1);

        // Reset in the middle of a load, then a clean reload.
        stream = {8'hA5, 8'h02, 8'h00, 8'h13};
        run_stream();
        active = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_s_ready", bus.s_ready, 0);
        check("midrst_hold", core_hold, 1);
        check("midrst_done", done, 0);
        check("midrst_wr_en", bus.wr_en, 0);
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        active = 1'b1;
        normal_frame(8'hA6);
        check("reload_addr0", cap_addr[0], 10'h000);
        check("reload_done", done, 1);

`ifdef LOADER_TIMEOUT_EN
        // Stop after A5 02: err 16 idle cycles after the last byte's edge.
        stream = {8'hA5, 8'h02};
        run_stream();
        check("tmo_err_early", err, 0);
        repeat (13) @(posedge clk);
        #1;
        exp_err = 1'b1;
        check("tmo_err", err, 1);
        check("tmo_hold", core_hold, 1);
        normal_frame(8'hA6);
        check("tmo_reload_done", done, 1);
        check("tmo_reload_err", err, 0);
`endif

        active = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
